lm32_dp_ram_wr_ctrl: RTL and testbench
======================================

Name: lm32_dp_ram_wr_ctrl

Overview:
- Write-port controller for the LM32 dual-port RAM (one write port, one registered read port).
- Initialises the whole array to zero after reset and on an explicit flush request, e.g. TLB/tag invalidate.
- Outside a flush, shares the single write port between two requesters using round-robin arbitration with a registered ack.
- The read port is not touched by this block.

Parameters:
- addr_width, 32, width of RAM address.
- addr_depth, 1024, number of RAM words; sweep covers 0..addr_depth-1.
- data_width, 8, width of RAM word.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- flush_i  in  1  request zero-sweep of the whole RAM; sampled every cycle.
- busy_o  out  1  high while a sweep is in progress.
- req0_valid_i  in  1  requester 0 write request.
- req0_addr_i  in  addr_width  requester 0 write address.
- req0_data_i  in  data_width  requester 0 write data.
- req0_ack_o  out  1  one-cycle pulse: req0 write issued this cycle.
- req1_valid_i, req1_addr_i, req1_data_i, req1_ack_o: same as requester 0, for requester 1.
- ram_we_o  out  1  RAM write enable.
- ram_waddr_o  out  addr_width  RAM write address.
- ram_wdata_o  out  data_width  RAM write data.

Behaviour:
- Clocking and outputs:
  - Clock clk_i; reset rst_i is asynchronous and active-high.
  - All outputs are registered.
- Reset values:
  - state=SWEEP, counter=0, busy_o=1.
  - ram_we_o=0, ram_waddr_o=0, ram_wdata_o=0.
  - req0_ack_o=0, req1_ack_o=0.
  - last_grant=1, so req0 wins the first tie.
- State machine, SWEEP:
  - Each cycle: ram_we_o=1, ram_waddr_o=counter, ram_wdata_o=0, counter++.
  - The write with counter=addr_depth-1 is the last; next state is IDLE.
  - busy_o drops in the same cycle ram_we_o drops after the last write.
  - A sweep therefore takes exactly addr_depth write cycles.
- State machine, IDLE:
  - If flush_i=1: next state SWEEP, counter=0, busy_o=1. No grant is issued in that cycle.
  - Otherwise, arbitrate between the eligible requesters.
- Eligibility: reqN is eligible when reqN_valid_i=1 and reqN_ack_o is not asserted in the current cycle.
  - This prevents a double-grant while the requester is still dropping valid after its ack.
- Arbitration:
  - If exactly one requester is eligible, grant it.
  - If both are eligible, grant the one that is not last_grant.
  - Update last_grant on every grant.
- Grant timing:
  - Request seen at cycle t.
  - At t+1: ram_we_o=1, ram_waddr_o/ram_wdata_o = the granted request's addr/data captured at t, and the winner's ackN=1 (one cycle).
  - Write latency is 1 cycle.
- Throughput:
  - One write per cycle overall.
  - At most one write per 2 cycles per requester when requesters alternate.
- Requester contract:
  - Hold valid, addr and data stable until the ack is seen.
  - Drop valid, or present a new request, in the cycle after the ack.
- flush_i during SWEEP is ignored; the sweep does not restart.
- Requests during SWEEP are neither acked nor lost; they wait and are arbitrated from IDLE.
- When no grant and no sweep write occur: ram_we_o=0, ram_waddr_o/ram_wdata_o hold their previous values.
- Reset mid-sweep or mid-grant: immediate return to reset values, and a full sweep restarts.
- Counter width: addr_width. The compare against addr_depth-1 is done at addr_width; addr_depth must be ≤ 2**addr_width.

Decomposition:
- Shared package holds:
  - state encoding constants: SWEEP=1'b0, IDLE=1'b1;
  - requester index constants: REQ0=1'b0, REQ1=1'b1.
- One natural sub-module: lm32_rr_arb2, the two-input round-robin arbiter with the last_grant register.
  - Inputs: two eligibility bits and an enable.
  - Outputs: one-hot grant.

Test Plan (addr_depth=16, addr_width=4, data_width=8):
- Reset release, no requests:
  - ram_we_o=1 for 16 consecutive cycles with ram_waddr_o 0..15 and data 0x00.
  - busy_o falls on cycle 17 and no ack fires during the sweep.
- After the sweep, only req0 valid (addr=5, data=0xA5):
  - Next cycle: ram_we_o=1, waddr=5, wdata=0xA5, req0_ack_o=1 for exactly one cycle.
  - No second write of the same request occurs in the following cycle.
- Both requesters valid and held continuously (req0 addr=1/0x11, req1 addr=2/0x22):
  - Writes alternate 1,2,1,2…; the first grant goes to req0.
  - ram_we_o stays high every cycle.
- flush_i pulsed in IDLE while req1 is valid:
  - The next 16 cycles are the zero sweep, busy_o=1 and req1 is not acked.
  - req1 is acked in the cycle after busy_o falls (its write is issued then).
- flush_i pulsed again at sweep address 7: the sweep continues to 15 without restarting (16 writes total).
- rst_i asserted asynchronously mid-grant (ram_we_o=1):
  - All outputs go to their reset values immediately, without waiting for a clock edge.
  - After release, a full 16-cycle sweep from address 0 follows.

Source files
------------

// File: rtl/lm32_dp_ram_wr_ctrl_pkg.sv
// Shared encodings for the LM32 dual-port RAM write-port controller.
package lm32_dp_ram_wr_ctrl_pkg;

   typedef enum logic {
      SWEEP = 1'b0,
      IDLE  = 1'b1
   } state_t;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/lm32_dp_ram_wr_ctrl_rr_arb2.sv
// Two-input round-robin arbiter; a tie goes to the requester not granted last.
module lm32_rr_arb2
   import lm32_dp_ram_wr_ctrl_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_en,
   input  logic [1:0] i_elig,
   output logic [1:0] o_grant
);

   logic r_last;
   logic w_both;

   assign w_both = i_elig[REQ0] & i_elig[REQ1];

   always_comb begin
      o_grant = 2'b00;
      if (i_en) begin
         if (w_both) begin
            if (r_last == REQ1) begin
               o_grant[REQ0] = 1'b1;
            end else begin
               o_grant[REQ1] = 1'b1;
            end
         end else if (i_elig[REQ0]) begin
            o_grant[REQ0] = 1'b1;
         end else if (i_elig[REQ1]) begin
            o_grant[REQ1] = 1'b1;
         end
      end
   end

   // Starts at REQ1 so requester 0 wins the first tie.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_last <= REQ1;
      end else if (o_grant[REQ1]) begin
         r_last <= REQ1;
      end else if (o_grant[REQ0]) begin
         r_last <= REQ0;
      end
   end

endmodule

// File: rtl/lm32_dp_ram_wr_ctrl.sv
// Write-port controller for the LM32 dual-port RAM: zero sweep after
// reset/flush, otherwise round-robin sharing between two requesters.
module lm32_dp_ram_wr_ctrl
   import lm32_dp_ram_wr_ctrl_pkg::*;
#(
   parameter int addr_width = 32,
   parameter int addr_depth = 1024,
   parameter int data_width = 8
)(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   output logic                  busy_o,
   input  logic                  req0_valid_i,
   input  logic [addr_width-1:0] req0_addr_i,
   input  logic [data_width-1:0] req0_data_i,
   output logic                  req0_ack_o,
   input  logic                  req1_valid_i,
   input  logic [addr_width-1:0] req1_addr_i,
   input  logic [data_width-1:0] req1_data_i,
   output logic                  req1_ack_o,
   output logic                  ram_we_o,
   output logic [addr_width-1:0] ram_waddr_o,
   output logic [data_width-1:0] ram_wdata_o
);

   localparam logic [addr_width-1:0] C_LAST =
      addr_width'(addr_depth - 1);

   state_t                r_state;
   logic [addr_width-1:0] r_cnt;

   state_t                w_state_nxt;
   logic [addr_width-1:0] w_cnt_nxt;
   logic                  w_busy_nxt;
   logic                  w_we_nxt;
   logic [addr_width-1:0] w_waddr_nxt;
   logic [data_width-1:0] w_wdata_nxt;
   logic                  w_ack0_nxt;
   logic                  w_ack1_nxt;
   logic                  w_arb_en;
   logic [1:0]            w_elig;
   logic [1:0]            w_grant;

   // A requester still seeing its ack is not re-granted.
   assign w_elig[REQ0] = req0_valid_i & ~req0_ack_o;
   assign w_elig[REQ1] = req1_valid_i & ~req1_ack_o;

   lm32_rr_arb2 u_arb (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_en    (w_arb_en),
      .i_elig  (w_elig),
      .o_grant (w_grant)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_busy_nxt  = busy_o;
      w_we_nxt    = 1'b0;
      w_waddr_nxt = ram_waddr_o;
      w_wdata_nxt = ram_wdata_o;
      w_ack0_nxt  = 1'b0;
      w_ack1_nxt  = 1'b0;
      w_arb_en    = 1'b0;
      unique case (r_state)
         SWEEP: begin
            w_we_nxt    = 1'b1;
            w_waddr_nxt = r_cnt;
            w_wdata_nxt = '0;
            w_busy_nxt  = 1'b1;
            w_cnt_nxt   = r_cnt + 1'b1;
            if (r_cnt == C_LAST) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end
         end
         IDLE: begin
            if (flush_i) begin
               w_state_nxt = SWEEP;
               w_cnt_nxt   = '0;
               w_busy_nxt  = 1'b1;
            end else if (busy_o) begin
               // Last sweep write is on the port; busy and we drop together.
               w_busy_nxt = 1'b0;
            end else begin
               w_arb_en = 1'b1;
               if (w_grant[REQ0]) begin
                  w_we_nxt    = 1'b1;
                  w_waddr_nxt = req0_addr_i;
                  w_wdata_nxt = req0_data_i;
                  w_ack0_nxt  = 1'b1;
               end else if (w_grant[REQ1]) begin
                  w_we_nxt    = 1'b1;
                  w_waddr_nxt = req1_addr_i;
                  w_wdata_nxt = req1_data_i;
                  w_ack1_nxt  = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= SWEEP;
         r_cnt       <= '0;
         busy_o      <= 1'b1;
         ram_we_o    <= 1'b0;
         ram_waddr_o <= '0;
         ram_wdata_o <= '0;
         req0_ack_o  <= 1'b0;
         req1_ack_o  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         busy_o      <= w_busy_nxt;
         ram_we_o    <= w_we_nxt;
         ram_waddr_o <= w_waddr_nxt;
         ram_wdata_o <= w_wdata_nxt;
         req0_ack_o  <= w_ack0_nxt;
         req1_ack_o  <= w_ack1_nxt;
      end
   end

endmodule

// File: tb/tb_lm32_dp_ram_wr_ctrl.sv
// Scoreboard bench for lm32_dp_ram_wr_ctrl at depth 16, 4-bit address.
module tb_lm32_dp_ram_wr_ctrl;

   localparam int AW = 4;
   localparam int DEPTH = 16;
   localparam int DW = 8;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [1:0]    ack;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush_i = 1'b0;
   logic          busy_o;
   logic          req0_valid_i = 1'b0;
   logic [AW-1:0] req0_addr_i = '0;
   logic [DW-1:0] req0_data_i = '0;
   logic          req0_ack_o;
   logic          req1_valid_i = 1'b0;
   logic [AW-1:0] req1_addr_i = '0;
   logic [DW-1:0] req1_data_i = '0;
   logic          req1_ack_o;
   logic          ram_we_o;
   logic [AW-1:0] ram_waddr_o;
   logic [DW-1:0] ram_wdata_o;

   int   n_vec = 0;
   int   n_miss = 0;
   exp_t sb[$];
   exp_t e_mon;

   always #5 clk = ~clk;

   lm32_dp_ram_wr_ctrl #(
      .addr_width (AW),
      .addr_depth (DEPTH),
      .data_width (DW)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .flush_i      (flush_i),
      .busy_o       (busy_o),
      .req0_valid_i (req0_valid_i),
      .req0_addr_i  (req0_addr_i),
      .req0_data_i  (req0_data_i),
      .req0_ack_o   (req0_ack_o),
      .req1_valid_i (req1_valid_i),
      .req1_addr_i  (req1_addr_i),
      .req1_data_i  (req1_data_i),
      .req1_ack_o   (req1_ack_o),
      .ram_we_o     (ram_we_o),
      .ram_waddr_o  (ram_waddr_o),
      .ram_wdata_o  (ram_wdata_o)
   );

   // Every write on the port must match the oldest expected write.
   always @(negedge clk) begin
      if (!rst) begin
         n_vec++;
         if (ram_we_o) begin
            if (sb.size() == 0) begin
               n_miss++;
               $display("FAIL unexpected_write: addr=%0d data=%02h", ram_waddr_o, ram_wdata_o);
            end else begin
               e_mon = sb.pop_front();
               if ({ram_waddr_o, ram_wdata_o, req1_ack_o, req0_ack_o} !== e_mon) begin
                  n_miss++;
                  $display("FAIL write_content: got a=%0d d=%02h ack=%b%b want a=%0d d=%02h ack=%b",
                           ram_waddr_o, ram_wdata_o, req1_ack_o, req0_ack_o, e_mon.a, e_mon.d, e_mon.ack);
               end
            end
         end else if ({req1_ack_o, req0_ack_o} !== 2'b00) begin
            n_miss++;
            $display("FAIL ack_without_write: ack=%b%b want 00", req1_ack_o, req0_ack_o);
         end
      end
   end

   task automatic push_sweep();
      for (int i = 0; i < DEPTH; i++) begin
         sb.push_back('{a: AW'(i), d: '0, ack: 2'b00});
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      n_vec++;
      if ({busy_o, ram_we_o, req1_ack_o, req0_ack_o} !== 4'b1000) begin
         n_miss++;
         $display("FAIL reset_ctrl: busy/we/ack1/ack0=%b want 1000",
                  {busy_o, ram_we_o, req1_ack_o, req0_ack_o});
      end
      n_vec++;
      if ({ram_waddr_o, ram_wdata_o} !== '0) begin
         n_miss++;
         $display("FAIL reset_bus: addr=%0d data=%02h want 0/00", ram_waddr_o, ram_wdata_o);
      end
      push_sweep();
      rst = 1'b0;
   endtask

   task automatic test_sweep(input string tag);
      for (int k = 1; k <= DEPTH; k++) begin
         @(negedge clk);
         n_vec++;
         if ({busy_o, ram_we_o} !== 2'b11) begin
            n_miss++;
            $display("FAIL %s_cycle%0d: busy/we=%b want 11", tag, k, {busy_o, ram_we_o});
         end
      end
      @(negedge clk);
      n_vec++;
      if ({busy_o, ram_we_o} !== 2'b00) begin
         n_miss++;
         $display("FAIL %s_end: busy/we=%b want 00", tag, {busy_o, ram_we_o});
      end
      n_vec++;
      if (sb.size() != 0) begin
         n_miss++;
         $display("FAIL %s_drained: left=%0d want 0", tag, sb.size());
      end
   endtask

   task automatic test_alternate();
      @(negedge clk);
      req0_valid_i = 1'b1; req0_addr_i = 4'd1; req0_data_i = 8'h11;
      req1_valid_i = 1'b1; req1_addr_i = 4'd2; req1_data_i = 8'h22;
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) sb.push_back('{a: 4'd1, d: 8'h11, ack: 2'b01});
         else            sb.push_back('{a: 4'd2, d: 8'h22, ack: 2'b10});
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_vec++;
         if (ram_we_o !== 1'b1) begin
            n_miss++;
            $display("FAIL alt_we%0d: we=%b want 1", i, ram_we_o);
         end
      end
      req0_valid_i = 1'b0;
      req1_valid_i = 1'b0;
      @(negedge clk);
      n_vec++;
      if (ram_we_o !== 1'b0 || sb.size() != 0) begin
         n_miss++;
         $display("FAIL alt_stop: we=%b left=%0d want 0/0", ram_we_o, sb.size());
      end
   endtask

   task automatic test_single();
      @(negedge clk);
      req0_valid_i = 1'b1; req0_addr_i = 4'd5; req0_data_i = 8'hA5;
      sb.push_back('{a: 4'd5, d: 8'hA5, ack: 2'b01});
      @(negedge clk);
      n_vec++;
      if ({ram_we_o, req0_ack_o} !== 2'b11) begin
         n_miss++;
         $display("FAIL single_grant: we/ack0=%b want 11", {ram_we_o, req0_ack_o});
      end
      @(negedge clk);
      req0_valid_i = 1'b0;
      n_vec++;
      if ({ram_we_o, req0_ack_o} !== 2'b00) begin
         n_miss++;
         $display("FAIL single_no_repeat: we/ack0=%b want 00", {ram_we_o, req0_ack_o});
      end
      n_vec++;
      if ({ram_waddr_o, ram_wdata_o} !== {4'd5, 8'hA5}) begin
         n_miss++;
         $display("FAIL single_hold: addr=%0d data=%02h want 5/a5", ram_waddr_o, ram_wdata_o);
      end
   endtask

   task automatic test_flush();
      @(negedge clk);
      req1_valid_i = 1'b1; req1_addr_i = 4'd9; req1_data_i = 8'h3C;
      flush_i = 1'b1;
      push_sweep();
      sb.push_back('{a: 4'd9, d: 8'h3C, ack: 2'b10});
      @(negedge clk);
      flush_i = 1'b0;
      n_vec++;
      if ({busy_o, ram_we_o, req1_ack_o} !== 3'b100) begin
         n_miss++;
         $display("FAIL flush_start: busy/we/ack1=%b want 100", {busy_o, ram_we_o, req1_ack_o});
      end
      for (int k = 1; k <= DEPTH; k++) begin
         @(negedge clk);
         n_vec++;
         if ({busy_o, ram_we_o, req1_ack_o} !== 3'b110) begin
            n_miss++;
            $display("FAIL flush_sweep%0d: busy/we/ack1=%b want 110",
                     k, {busy_o, ram_we_o, req1_ack_o});
         end
      end
      @(negedge clk);
      n_vec++;
      if ({busy_o, ram_we_o, req1_ack_o} !== 3'b000) begin
         n_miss++;
         $display("FAIL flush_end: busy/we/ack1=%b want 000", {busy_o, ram_we_o, req1_ack_o});
      end
      @(negedge clk);
      n_vec++;
      if ({busy_o, ram_we_o, req1_ack_o} !== 3'b011) begin
         n_miss++;
         $display("FAIL flush_req1_ack: busy/we/ack1=%b want 011", {busy_o, ram_we_o, req1_ack_o});
      end
      @(negedge clk);
      req1_valid_i = 1'b0;
      n_vec++;
      if (ram_we_o !== 1'b0 || sb.size() != 0) begin
         n_miss++;
         $display("FAIL flush_quiet: we=%b left=%0d want 0/0", ram_we_o, sb.size());
      end
   endtask

   task automatic test_flush_mid_sweep();
      int  writes = 0;
      bit  pulsed = 0;
      bit  done = 0;
      @(negedge clk);
      flush_i = 1'b1;
      push_sweep();
      @(negedge clk);
      flush_i = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge clk);
         flush_i = 1'b0;
         if (ram_we_o) writes++;
         if (ram_we_o && ram_waddr_o == 4'd7 && !pulsed) begin
            flush_i = 1'b1;
            pulsed = 1;
         end
         if (!busy_o) done = 1;
      end
      flush_i = 1'b0;
      n_vec++;
      if (!done) begin
         n_miss++;
         $display("FAIL midflush_timeout: busy stuck at %b want 0", busy_o);
      end
      n_vec++;
      if (writes != DEPTH || sb.size() != 0) begin
         n_miss++;
         $display("FAIL midflush_count: writes=%0d left=%0d want %0d/0", writes, sb.size(), DEPTH);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      req0_valid_i = 1'b1; req0_addr_i = 4'd3; req0_data_i = 8'h77;
      sb.push_back('{a: 4'd3, d: 8'h77, ack: 2'b01});
      @(negedge clk);
      n_vec++;
      if ({ram_we_o, req0_ack_o} !== 2'b11) begin
         n_miss++;
         $display("FAIL arst_pre: we/ack0=%b want 11", {ram_we_o, req0_ack_o});
      end
      #2 rst = 1'b1;
      #1;
      n_vec++;
      if ({busy_o, ram_we_o, req1_ack_o, req0_ack_o} !== 4'b1000 ||
          {ram_waddr_o, ram_wdata_o} !== '0) begin
         n_miss++;
         $display("FAIL arst_immediate: busy/we/acks=%b addr=%0d data=%02h want 1000/0/00",
                  {busy_o, ram_we_o, req1_ack_o, req0_ack_o}, ram_waddr_o, ram_wdata_o);
      end
      req0_valid_i = 1'b0;
      @(negedge clk);
      push_sweep();
      rst = 1'b0;
      test_sweep("arst_sweep");
   endtask

   initial begin
      test_reset();
      test_sweep("sweep");
      test_alternate();
      test_single();
      test_flush();
      test_flush_mid_sweep();
      test_async_reset();
      @(negedge clk);
      n_vec++;
      if (sb.size() != 0) begin
         n_miss++;
         $display("FAIL final_drain: left=%0d want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
